// File: rtl/ifu_axi_master_pkg.sv
// Shared AXI-lite bus macros and instruction-fetch FSM types.
// The macros are guarded so that an existing defines header may provide them first.
`ifndef AXI_ADDR_BUS
`define AXI_ADDR_BUS 31:0
`endif
`ifndef AXI_DATA_BUS
`define AXI_DATA_BUS 31:0
`endif
`ifndef AXI_RESP_BUS
`define AXI_RESP_BUS 1:0
`endif
`ifndef AXI_WSTRB_BUS
`define AXI_WSTRB_BUS 3:0
`endif
`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif
`ifndef AXI_RESP_OKAY
`define AXI_RESP_OKAY 2'b00
`endif

package ifu_axi_master_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_OUT
    } fetch_state_t;

    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ifu_axi_master.sv
// Instruction-fetch AXI-lite master: one outstanding read per instruction,
// fetched word handed to decode over valid/ready; write channels tied off.
module ifu_axi_master
    import ifu_axi_master_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFU_RESET_PC,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [`AXI_ADDR_BUS]  redirect_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [`AXI_DATA_BUS]  inst,
    output logic [`AXI_ADDR_BUS]  inst_pc,
    output logic                  inst_err,
    output logic [`AXI_ADDR_BUS]  araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [`AXI_DATA_BUS]  rdata,
    input  logic [`AXI_RESP_BUS]  rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [`AXI_ADDR_BUS]  awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [`AXI_DATA_BUS]  wdata,
    output logic [`AXI_WSTRB_BUS] wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [`AXI_RESP_BUS]  bresp,
    input  logic                  bvalid,
    output logic                  bready
);

    fetch_state_t         state_q;
    logic [`AXI_ADDR_BUS] pc_q;
    logic                 drop_q;
    logic [`AXI_ADDR_BUS] araddr_q;
    logic                 arvalid_q;
    logic                 rready_q;
    logic                 inst_valid_q;
    logic [`AXI_DATA_BUS] inst_q;
    logic [`AXI_ADDR_BUS] inst_pc_q;
    logic                 inst_err_q;

    logic [`AXI_ADDR_BUS] pc_step_d;
    logic [`AXI_ADDR_BUS] refetch_pc_d;
    logic                 unused_wr_chan;

    assign pc_step_d    = pc_q + PC_STEP;
    // A redirect in the same cycle as the retry must win over the stored pc.
    assign refetch_pc_d = redirect_valid ? redirect_pc : pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            drop_q       <= 1'b0;
            araddr_q     <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= `INST_NOP;
            inst_pc_q    <= '0;
            inst_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    pc_q      <= refetch_pc_d;
                    araddr_q  <= refetch_pc_d;
                    arvalid_q <= 1'b1;
                    state_q   <= S_AR;
                end
                S_AR: begin
                    // araddr is never touched here; a redirect only marks the read stale.
                    if (redirect_valid) begin
                        pc_q   <= redirect_pc;
                        drop_q <= 1'b1;
                    end
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_R;
                    end
                end
                S_R: begin
                    if (rvalid && rready_q) begin
                        rready_q <= 1'b0;
                        if (drop_q || redirect_valid) begin
                            drop_q    <= 1'b0;
                            pc_q      <= refetch_pc_d;
                            araddr_q  <= refetch_pc_d;
                            arvalid_q <= 1'b1;
                            state_q   <= S_AR;
                        end else begin
                            inst_q       <= rdata;
                            inst_pc_q    <= pc_q;
                            inst_err_q   <= (rresp != `AXI_RESP_OKAY);
                            inst_valid_q <= 1'b1;
                            state_q      <= S_OUT;
                        end
                    end else if (redirect_valid) begin
                        pc_q   <= redirect_pc;
                        drop_q <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (redirect_valid) begin
                        inst_valid_q <= 1'b0;
                        pc_q         <= redirect_pc;
                        araddr_q     <= redirect_pc;
                        arvalid_q    <= 1'b1;
                        state_q      <= S_AR;
                    end else if (inst_ready) begin
                        inst_valid_q <= 1'b0;
                        pc_q         <= pc_step_d;
                        araddr_q     <= pc_step_d;
                        arvalid_q    <= 1'b1;
                        state_q      <= S_AR;
                    end
                end
            endcase
        end
    end

    assign araddr     = araddr_q;
    assign arvalid    = arvalid_q;
    assign rready     = rready_q;
    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_err   = inst_err_q;

    assign awaddr  = '0;
    assign awvalid = 1'b0;
    assign wdata   = '0;
    assign wstrb   = '0;
    assign wvalid  = 1'b0;
    assign bready  = 1'b0;

    assign unused_wr_chan = ^{awready, wready, bresp, bvalid};

endmodule

// File: tb/tb_ifu_axi_master.sv
// Bench for ifu_axi_master: AXI-lite slave with configurable latency plus an
// expected-instruction-stream model derived from pc/redirect/accept rules.
module tb_ifu_axi_master;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_err;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        bready;

    int n_checks = 0;
    int n_fail   = 0;

    ifu_axi_master #(
        .RESET_PC (32'h8000_0000),
        .PC_STEP  (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_err       (inst_err),
        .araddr         (araddr),
        .arvalid        (arvalid),
        .arready        (arready),
        .rdata          (rdata),
        .rresp          (rresp),
        .rvalid         (rvalid),
        .rready         (rready),
        .awaddr         (awaddr),
        .awvalid        (awvalid),
        .awready        (1'b1),
        .wdata          (wdata),
        .wstrb          (wstrb),
        .wvalid         (wvalid),
        .wready         (1'b1),
        .bresp          (2'b00),
        .bvalid         (1'b0),
        .bready         (bready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- slave memory and timing model ----------------
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    bit          rand_err = 0;
    bit          rand_lat = 0;
    int          ar_lat = 0, r_lat = 0;
    int          ar_wait = 0, r_wait = 0;
    bit          pending = 0;
    logic [31:0] pend_addr = '0;
    int          ar_hs = 0, r_hs = 0, ooo_err = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0413;
        return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
    endfunction

    function automatic logic err_of(input logic [31:0] a);
        return (a == err_addr) || (rand_err && a[4:2] == 3'b111);
    endfunction

    always @(negedge clk) begin
        arready = arvalid && (ar_wait >= ar_lat);
        rvalid  = pending && (r_wait >= r_lat);
        rdata   = rvalid ? mem_word(pend_addr) : 32'hDEAD_BEEF;
        rresp   = (rvalid && err_of(pend_addr)) ? 2'b10 : 2'b00;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pending = 0;
            ar_wait = 0;
            r_wait  = 0;
        end else begin
            if (rvalid && rready) begin
                pending = 0;
                r_hs++;
            end else if (pending) begin
                r_wait++;
            end
            if (arvalid && arready) begin
                if (pending) ooo_err++;
                pending   = 1;
                pend_addr = araddr;
                ar_hs++;
                ar_wait = 0;
                r_wait  = 0;
                if (rand_lat) begin
                    ar_lat = $urandom_range(0, 3);
                    r_lat  = $urandom_range(0, 3);
                end
            end else if (arvalid) begin
                ar_wait++;
            end
        end
    end

    initial begin
        arready = 1'b0;
        rvalid  = 1'b0;
        rdata   = '0;
        rresp   = '0;
    end

    // ---------------- helpers (stimulus only) ----------------
    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b1;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // sel: 0 = arvalid, 1 = inst_valid, 2 = rready
    task automatic wait_sig(input int sel, input int max, output bit ok, output int cyc);
        ok  = 0;
        cyc = 0;
        while (cyc < max) begin
            @(negedge clk);
            #1;
            cyc++;
            if ((sel == 0 && arvalid) || (sel == 1 && inst_valid) || (sel == 2 && rready)) begin
                ok = 1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({arvalid, rready, inst_valid, inst_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got arvalid/rready/inst_valid/inst_err=%b want 0000",
                     {arvalid, rready, inst_valid, inst_err});
        end
        n_checks++;
        if (inst !== 32'h0000_0013 || inst_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_inst: got inst=%h inst_pc=%h want 00000013/00000000", inst, inst_pc);
        end
        n_checks++;
        if ({awvalid, wvalid, bready} !== 3'b000 || awaddr !== 32'h0 || wdata !== 32'h0 || wstrb !== 4'h0) begin
            n_fail++;
            $display("FAIL write_tieoff: got awvalid=%b wvalid=%b bready=%b awaddr=%h wdata=%h wstrb=%h want all 0",
                     awvalid, wvalid, bready, awaddr, wdata, wstrb);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_first_fetch();
        bit ok;
        int c1, c2;
        ar_lat = 0; r_lat = 0;
        inst_ready = 1'b1;
        wait_sig(0, 10, ok, c1);
        n_checks++;
        if (!ok || araddr !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL first_araddr: got ok=%0d araddr=%h want 80000000", ok, araddr);
        end
        wait_sig(1, 10, ok, c2);
        n_checks++;
        if (!ok || inst !== 32'h0000_0413 || inst_pc !== 32'h8000_0000 || inst_err !== 1'b0) begin
            n_fail++;
            $display("FAIL first_inst: got ok=%0d inst=%h pc=%h err=%b want 00000413/80000000/0",
                     ok, inst, inst_pc, inst_err);
        end
        n_checks++;
        if (c1 + c2 < 3) begin
            n_fail++;
            $display("FAIL first_latency: got %0d cycles want >= 3", c1 + c2);
        end
        wait_sig(0, 10, ok, c1);
        n_checks++;
        if (!ok || araddr !== 32'h8000_0004) begin
            n_fail++;
            $display("FAIL second_araddr: got ok=%0d araddr=%h want 80000004", ok, araddr);
        end
    endtask

    task automatic test_ar_stall();
        bit ok;
        int c;
        int r0;
        logic [31:0] a0;
        ar_lat = 5; r_lat = 0;
        do_reset();
        inst_ready = 1'b1;
        wait_sig(0, 10, ok, c);
        a0 = araddr;
        r0 = r_hs;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (arvalid !== 1'b1 || araddr !== a0 || arready !== 1'b0) begin
                n_fail++;
                $display("FAIL ar_hold[%0d]: got arvalid=%b araddr=%h arready=%b want 1/%h/0",
                         i, arvalid, araddr, arready, a0);
            end
            @(negedge clk);
            #1;
        end
        n_checks++;
        if (arvalid !== 1'b1 || arready !== 1'b1 || araddr !== a0) begin
            n_fail++;
            $display("FAIL ar_hs6: got arvalid=%b arready=%b araddr=%h want 1/1/%h", arvalid, arready, araddr, a0);
        end
        inst_ready = 1'b0;
        wait_sig(1, 20, ok, c);
        n_checks++;
        if (!ok || r_hs !== r0 + 1 || inst_pc !== a0) begin
            n_fail++;
            $display("FAIL ar_stall_r: got ok=%0d r_accepted=%0d pc=%h want 1/%0d/%h", ok, r_hs - r0, inst_pc, 1, a0);
        end
        ar_lat = 0;
    endtask

    task automatic test_out_stall();
        bit ok;
        int c, a0;
        logic [31:0] i0, p0;
        ar_lat = 0; r_lat = 0;
        do_reset();
        inst_ready = 1'b0;
        wait_sig(1, 20, ok, c);
        i0 = inst; p0 = inst_pc; a0 = ar_hs;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (inst_valid !== 1'b1 || inst !== i0 || inst_pc !== p0 || arvalid !== 1'b0 || ar_hs != a0) begin
                n_fail++;
                $display("FAIL out_hold[%0d]: got v=%b inst=%h pc=%h arvalid=%b ar_count=%0d want 1/%h/%h/0/%0d",
                         i, inst_valid, inst, inst_pc, arvalid, ar_hs, i0, p0, a0);
            end
        end
        inst_ready = 1'b1;
        @(negedge clk);
        #1;
        inst_ready = 1'b0;
        n_checks++;
        if (arvalid !== 1'b1 || araddr !== p0 + 32'd4 || inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL out_release: got arvalid=%b araddr=%h inst_valid=%b want 1/%h/0",
                     arvalid, araddr, inst_valid, p0 + 32'd4);
        end
    endtask

    task automatic test_redirect_in_r();
        bit ok;
        int c;
        ar_lat = 0; r_lat = 3;
        do_reset();
        inst_ready = 1'b1;
        wait_sig(2, 10, ok, c);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        @(negedge clk);
        #1;
        redirect_valid = 1'b0;
        wait_sig(0, 20, ok, c);
        n_checks++;
        if (!ok || araddr !== 32'h8000_0100) begin
            n_fail++;
            $display("FAIL redir_r_araddr: got ok=%0d araddr=%h want 80000100", ok, araddr);
        end
        wait_sig(1, 20, ok, c);
        n_checks++;
        if (!ok || inst_pc !== 32'h8000_0100 || inst !== mem_word(32'h8000_0100)) begin
            n_fail++;
            $display("FAIL redir_r_inst: got ok=%0d pc=%h inst=%h want 80000100/%h",
                     ok, inst_pc, inst, mem_word(32'h8000_0100));
        end
        r_lat = 0;
    endtask

    task automatic test_redirect_with_ready();
        bit ok;
        int c;
        ar_lat = 0; r_lat = 0;
        do_reset();
        inst_ready = 1'b0;
        wait_sig(1, 20, ok, c);
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        @(negedge clk);
        #1;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        n_checks++;
        if (arvalid !== 1'b1 || araddr !== 32'h8000_0200 || inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_out: got arvalid=%b araddr=%h inst_valid=%b want 1/80000200/0",
                     arvalid, araddr, inst_valid);
        end
        wait_sig(1, 20, ok, c);
        n_checks++;
        if (!ok || inst_pc !== 32'h8000_0200) begin
            n_fail++;
            $display("FAIL redir_out_inst: got ok=%0d pc=%h want 80000200", ok, inst_pc);
        end
    endtask

    task automatic test_error();
        bit ok;
        int c;
        ar_lat = 0; r_lat = 0;
        err_addr = 32'h8000_0000;
        do_reset();
        inst_ready = 1'b0;
        wait_sig(1, 20, ok, c);
        n_checks++;
        if (!ok || inst_err !== 1'b1 || inst !== 32'h0000_0413) begin
            n_fail++;
            $display("FAIL err_inst: got ok=%0d err=%b inst=%h want 1/1/00000413", ok, inst_err, inst);
        end
        inst_ready = 1'b1;
        wait_sig(0, 10, ok, c);
        n_checks++;
        if (!ok || araddr !== 32'h8000_0004) begin
            n_fail++;
            $display("FAIL err_advance: got ok=%0d araddr=%h want 80000004", ok, araddr);
        end
        wait_sig(1, 20, ok, c);
        n_checks++;
        if (!ok || inst_err !== 1'b0 || inst_pc !== 32'h8000_0004) begin
            n_fail++;
            $display("FAIL err_next: got ok=%0d err=%b pc=%h want 1/0/80000004", ok, inst_err, inst_pc);
        end
        err_addr = 32'hFFFF_FFFF;
    endtask

    task automatic test_async_reset();
        bit ok;
        int c;
        ar_lat = 0; r_lat = 3;
        do_reset();
        inst_ready = 1'b1;
        wait_sig(2, 10, ok, c);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({arvalid, rready, inst_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL async_rst_r: got arvalid/rready/inst_valid=%b want 000", {arvalid, rready, inst_valid});
        end
        @(negedge clk);
        rst = 1'b0;
        r_lat = 0;
        inst_ready = 1'b0;
        wait_sig(0, 10, ok, c);
        n_checks++;
        if (!ok || araddr !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL async_rst_restart: got ok=%0d araddr=%h want 80000000", ok, araddr);
        end
        wait_sig(1, 20, ok, c);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (inst_valid !== 1'b0 || arvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst_out: got inst_valid=%b arvalid=%b want 0/0", inst_valid, arvalid);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        bit          hold_ar, hold_out;
        logic [31:0] prev_araddr, prev_inst, prev_pc;
        logic        prev_err;
        int          delivered = 0;
        rand_lat = 1;
        rand_err = 1;
        do_reset();
        exp_pc = 32'h8000_0000;
        hold_ar = 0;
        hold_out = 0;
        prev_araddr = '0; prev_inst = '0; prev_pc = '0; prev_err = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            #1;
            inst_ready     = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFFC;
            else redirect_pc = 32'h8000_0000 + ($urandom_range(0, 255) << 2);
            if (inst_valid) begin
                n_checks++;
                if (inst_pc !== exp_pc || inst !== mem_word(exp_pc) || inst_err !== err_of(exp_pc)) begin
                    n_fail++;
                    $display("FAIL rand_inst@%0d: got pc=%h inst=%h err=%b want %h/%h/%b",
                             cyc, inst_pc, inst, inst_err, exp_pc, mem_word(exp_pc), err_of(exp_pc));
                end
                n_checks++;
                if (arvalid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_ar_during_out@%0d: got arvalid=%b want 0", cyc, arvalid);
                end
            end
            if (hold_ar) begin
                n_checks++;
                if (arvalid !== 1'b1 || araddr !== prev_araddr) begin
                    n_fail++;
                    $display("FAIL rand_ar_hold@%0d: got arvalid=%b araddr=%h want 1/%h", cyc, arvalid, araddr, prev_araddr);
                end
            end
            if (hold_out) begin
                n_checks++;
                if (inst_valid !== 1'b1 || inst !== prev_inst || inst_pc !== prev_pc || inst_err !== prev_err) begin
                    n_fail++;
                    $display("FAIL rand_out_hold@%0d: got v=%b inst=%h pc=%h err=%b want 1/%h/%h/%b",
                             cyc, inst_valid, inst, inst_pc, inst_err, prev_inst, prev_pc, prev_err);
                end
            end
            hold_ar     = arvalid && !arready;
            prev_araddr = araddr;
            hold_out    = inst_valid && !inst_ready && !redirect_valid;
            prev_inst   = inst;
            prev_pc     = inst_pc;
            prev_err    = inst_err;
            if (redirect_valid) exp_pc = redirect_pc;
            else if (inst_valid && inst_ready) begin
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
        end
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        rand_lat = 0;
        rand_err = 0;
        n_checks++;
        if (delivered < 50 || ooo_err != 0) begin
            n_fail++;
            $display("FAIL rand_progress: got delivered=%0d outstanding_violations=%0d want >=50/0", delivered, ooo_err);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_first_fetch();
        test_ar_stall();
        test_out_stall();
        test_redirect_in_r();
        test_redirect_with_ready();
        test_error();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifu_axi_master.md
Name: ifu_axi_master

Overview:
Instruction-fetch AXI-lite master. It holds the fetch PC, issues one read per instruction on the AR channel, and accepts the word on the R channel. It presents the fetched instruction to the decode stage over a valid/ready interface. It sits between the core's fetch stage and the instruction SRAM / AXI-lite slave, and is read-only: the write channels are tied off.

Parameters:
RESET_PC, 32'h8000_0000, first fetch address after reset
PC_STEP, 4, PC increment after each instruction accepted by decode

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
redirect_valid  in  1  branch/jump/trap redirect request
redirect_pc  in  `AXI_ADDR_BUS  new fetch address
inst_valid  out  1  fetched instruction available to decode
inst_ready  in  1  decode accepts instruction
inst  out  `AXI_DATA_BUS  instruction word
inst_pc  out  `AXI_ADDR_BUS  address of inst
inst_err  out  1  rresp != OKAY for this fetch
araddr  out  `AXI_ADDR_BUS  read address
arvalid  out  1  AR valid
arready  in  1  AR ready
rdata  in  `AXI_DATA_BUS  read data
rresp  in  `AXI_RESP_BUS  read response
rvalid  in  1  R valid
rready  out  1  R ready
awaddr  out  `AXI_ADDR_BUS  tied 0
awvalid  out  1  tied 0
awready  in  1  ignored
wdata  out  `AXI_DATA_BUS  tied 0
wstrb  out  `AXI_WSTRB_BUS  tied 0
wvalid  out  1  tied 0
wready  in  1  ignored
bresp  in  `AXI_RESP_BUS  ignored
bvalid  in  1  ignored
bready  out  1  tied 0

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_PC, state=S_IDLE, drop=0
  - arvalid=0, rready=0, inst_valid=0, inst=`INST_NOP, inst_pc=0, inst_err=0
- FSM states: S_IDLE, S_AR, S_R, S_OUT. All outputs are registered.
- S_IDLE: one cycle after reset release, go to S_AR with arvalid=1, araddr=pc.
- S_AR:
  - araddr and arvalid stay stable until arready; arvalid never drops before the handshake.
  - On arvalid&&arready: arvalid=0, rready=1, go to S_R.
- S_R:
  - rready=1. On rvalid&&rready: rready=0.
  - If drop=0: inst<=rdata, inst_pc<=pc, inst_err<=(rresp!=OKAY), inst_valid<=1, go to S_OUT.
  - If drop=1: discard the data, drop<=0, arvalid<=1, araddr<=pc, go to S_AR.
- S_OUT:
  - inst, inst_pc and inst_err stay stable while inst_valid=1.
  - On inst_valid&&inst_ready: inst_valid<=0, pc<=pc+PC_STEP (wraps mod 2^32), arvalid<=1, araddr<=pc+PC_STEP, go to S_AR.
- Redirect, any state, sampled every cycle:
  - S_IDLE: pc<=redirect_pc.
  - S_AR: pc<=redirect_pc. arvalid and the current araddr are held (no change mid-handshake) and drop<=1. If arready arrives in the same cycle, go to S_R with drop=1.
  - S_R: pc<=redirect_pc, drop<=1. If rvalid arrives in the same cycle, discard it and go directly to S_AR at redirect_pc.
  - S_OUT: inst_valid<=0, pc<=redirect_pc, go to S_AR at redirect_pc. Redirect wins over a simultaneous inst_ready; that instruction counts as not consumed.
- Error handling: an errored fetch is still delivered with inst_err=1. PC advance is unchanged; trap handling belongs to decode.
- Throughput and latency:
  - At most one outstanding read.
  - Minimum 3 cycles per instruction (AR, R, OUT) when arready, rvalid and inst_ready are all 1.
  - First inst_valid appears no earlier than cycle 4 after reset release.
- rvalid outside S_R is ignored (rready=0).
- The PC is not alignment-checked.

Decomposition:
- Shared defines (existing defines header): `AXI_ADDR_BUS, `AXI_DATA_BUS, `AXI_RESP_BUS, `AXI_WSTRB_BUS, `INST_NOP, plus new `AXI_RESP_OKAY=2'b00.
- New package: fetch_state_t enum (S_IDLE, S_AR, S_R, S_OUT) and the RESET_PC default.
- No sub-module; single FSM plus registers.

Test Plan:
- Reset, slave with arready=1, rvalid one cycle after AR, memory[0x80000000]=0x00000413, inst_ready=1 -> araddr=0x80000000; inst_valid=1 with inst=0x00000413, inst_pc=0x80000000, inst_err=0; next araddr=0x80000004.
- arready held 0 for 5 cycles -> arvalid=1 and araddr constant for all 5 cycles; handshake on cycle 6; exactly one R accepted.
- inst_ready=0 for 4 cycles in S_OUT -> inst and inst_pc stable, no new AR issued; after inst_ready=1, next AR at pc+4.
- redirect_valid with redirect_pc=0x80000100 while in S_R -> returned data discarded, inst_valid never pulses for the old pc, next araddr=0x80000100.
- Redirect in the same cycle as inst_ready in S_OUT -> next araddr=redirect_pc, not pc+4.
- rresp=2'b10 -> inst_valid=1, inst_err=1, pc still advances by 4; async rst asserted mid-S_R -> arvalid, rready and inst_valid go 0 immediately, and the first araddr after release is 0x80000000.
